fetch_ctrl: RTL



---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_ctrl.sv | 89 ++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction-memory geometry, halt encoding and the
// fetch sequencer state type (also visible to decode/control for debug).
package cpu_pkg;

    localparam int              CPU_ADDR_W    = 4;
    localparam int              CPU_DATA_W    = 16;
    localparam logic [15:0]     CPU_HALT_WORD = 16'hFFFF;
    localparam logic [3:0]      CPU_RESET_PC  = 4'h0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Saturating 16-bit increment used by the fetch counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the async-read instruction
// memory and hands captured words to decode through a valid/ready register.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int                 ADDR_W    = CPU_ADDR_W,
    parameter int                 DATA_W    = CPU_DATA_W,
    parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(CPU_RESET_PC),
    parameter logic [DATA_W-1:0]  HALT_WORD = DATA_W'(CPU_HALT_WORD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_inst_pc;
    logic              r_inst_valid;
    logic              r_halted;
    logic [15:0]       r_fetch_count;

    logic w_fetch;
    logic w_xfer;
    logic w_start_ok;
    logic w_is_halt;

    // Redirect suppresses the fetch so a stale word is never captured.
    assign w_fetch    = (r_state == RUN) && !redirect && (!r_inst_valid || inst_ready);
    assign w_xfer     = r_inst_valid && inst_ready;
    assign w_start_ok = start && (r_state != RUN);
    assign w_is_halt  = (imem_data == HALT_WORD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_inst        <= '0;
            r_inst_pc     <= '0;
            r_inst_valid  <= 1'b0;
            r_halted      <= 1'b0;
            r_fetch_count <= '0;
        end else if (redirect) begin
            r_pc         <= redirect_pc;
            r_inst_valid <= 1'b0;
            if (w_start_ok) begin
                r_state  <= RUN;
                r_halted <= 1'b0;
            end
        end else begin
            if (w_start_ok) begin
                r_state  <= RUN;
                r_halted <= 1'b0;
            end
            if (w_fetch) begin
                r_inst        <= imem_data;
                r_inst_pc     <= r_pc;
                r_inst_valid  <= 1'b1;
                r_pc          <= r_pc + ADDR_W'(1);
                r_fetch_count <= sat_inc16(r_fetch_count);
                if (w_is_halt) begin
                    r_state  <= HALTED;
                    r_halted <= 1'b1;
                end
            end else if (w_xfer) begin
                r_inst_valid <= 1'b0;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign inst        = r_inst;
    assign inst_pc     = r_inst_pc;
    assign inst_valid  = r_inst_valid;
    assign halted      = r_halted;
    assign fetch_count = r_fetch_count;

endmodule
